// File: rtl/rr_mux_pkg.sv
// Shared constants, output-stage state type and width helper for the round-robin arbitrating mux.
package rr_mux_pkg;

  localparam int unsigned RR_MUX_MAX_CH = 16;
  localparam int unsigned BEAT_CNT_W    = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Channel index width; never narrower than one bit.
  function automatic int unsigned ch_index_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority grant search and the round-robin pointer register.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  localparam int unsigned CH_W = ch_index_w(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in_valid,
  input  logic            advance,
  output logic [CH_W-1:0] grant,
  output logic            any_valid
);

  logic [CH_W-1:0] rr_ptr;

  // First requester at or after rr_ptr, wrapping modulo N_CH.
  always_comb begin
    logic [CH_W-1:0] idx;
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      idx = CH_W'((32'(rr_ptr) + 32'(k)) % N_CH);
      if (!any_valid && in_valid[idx]) begin
        grant     = idx;
        any_valid = 1'b1;
      end
    end
  end

  // Pointer moves past the winner only on an accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_W'(1);
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux with valid/ready on every port and a one-entry output stage.
// Optional beat counter (beat_cnt, cnt_clr) is built when RR_MUX_CNT_EN is defined.
module rr_arb_mux
  import rr_mux_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned CH_W  = ch_index_w(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
`ifdef RR_MUX_CNT_EN
  ,
  input  logic                     cnt_clr,
  output logic [BEAT_CNT_W-1:0]    beat_cnt
`endif
);

  out_state_e      state;
  logic [CH_W-1:0] grant;
  logic            any_valid;
  logic            load_en;
  logic            xfer;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter #(.N_CH(N_CH)) u_arbiter (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .advance   (xfer),
    .grant     (grant),
    .any_valid (any_valid)
  );

  assign out_valid = (state == OUT_FULL);
  assign load_en   = !out_valid || out_ready;
  assign xfer      = load_en && any_valid && !rst;

  // One-hot accept to the granted channel; data mux by the same index.
  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (grant == CH_W'(i)) begin
        in_ready[i] = xfer;
        sel_data    = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output stage: load replaces (even while draining), drain alone empties, stall holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OUT_EMPTY;
      out_data <= '0;
      out_ch   <= '0;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (xfer) begin
            state    <= OUT_FULL;
            out_data <= sel_data;
            out_ch   <= grant;
          end
        end
        OUT_FULL: begin
          if (xfer) begin
            out_data <= sel_data;
            out_ch   <= grant;
          end else if (out_ready) begin
            state <= OUT_EMPTY;
          end
        end
      endcase
    end
  end

`ifdef RR_MUX_CNT_EN
  // Saturating handshake counter; clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (cnt_clr) begin
      beat_cnt <= '0;
    end else if (xfer && (beat_cnt != '1)) begin
      beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux (4 channels x 8 bits); counter tests need RR_MUX_CNT_EN.
module tb_rr_arb_mux;

  localparam int N_CH   = 4;
  localparam int DATA_W = 8;
  localparam int CH_W   = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_CH-1:0]        in_valid = '0;
  logic [N_CH*DATA_W-1:0] in_data = '0;
  logic [N_CH-1:0]        in_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [CH_W-1:0]        out_ch;
  logic                   out_ready = 1'b0;
`ifdef RR_MUX_CNT_EN
  logic                   cnt_clr = 1'b0;
  logic [15:0]            beat_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  beat_t exp_q[$];
  int    m_ptr  = 0;
  bit    m_full = 1'b0;

  rr_arb_mux #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
`ifdef RR_MUX_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .beat_cnt  (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference grant: rotating search from the model pointer, gated by output-stage space.
  function automatic logic [N_CH-1:0] exp_ready();
    logic [N_CH-1:0] r;
    int c;
    r = '0;
    if (m_full && !out_ready) return r;
    for (int k = 0; k < N_CH; k++) begin
      c = (m_ptr + k) % N_CH;
      if (in_valid[c]) begin
        r[c] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic int onehot_idx(input logic [N_CH-1:0] v);
    for (int i = 0; i < N_CH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_data(input int ch, input logic [DATA_W-1:0] d);
    in_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_full = 1'b0;
    m_ptr  = 0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b1;
`ifdef RR_MUX_CNT_EN
    cnt_clr   = 1'b0;
`endif
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Scoreboard monitor: checks ready and output each cycle, then predicts the coming edge.
  always @(negedge clk) begin : monitor
    logic [N_CH-1:0] er;
    int c;
    beat_t b;
    if (!rst) begin
      er = exp_ready();
      n_checks++;
      if (in_ready !== er) begin
        n_fail++;
        $display("FAIL in_ready t=%0t got %b want %b", $time, in_ready, er);
      end
      n_checks++;
      if (out_valid !== m_full) begin
        n_fail++;
        $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, m_full);
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty t=%0t got data %h ch %0d want no beat", $time, out_data, out_ch);
        end else begin
          if ({out_data, out_ch} !== exp_q[0]) begin
            n_fail++;
            $display("FAIL sb_beat t=%0t got data %h ch %0d want data %h ch %0d",
                     $time, out_data, out_ch, exp_q[0].data, exp_q[0].ch);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (er != '0) begin
        c = onehot_idx(er);
        b.data = in_data[c*DATA_W +: DATA_W];
        b.ch   = CH_W'(c);
        exp_q.push_back(b);
        m_ptr  = (c + 1) % N_CH;
        m_full = 1'b1;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic test_reset();
    in_valid = 4'b1111;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || in_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b d=%h ch=%0d rdy=%b want 0 0 0 0", out_valid, out_data, out_ch, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0; in_valid = 4'b0100; set_data(2, 8'h5A);
    @(posedge clk); #1;
    in_valid = '0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_preload got v=%b ch=%0d want 1 2", out_valid, out_ch);
    end
    #2 rst = 1'b1; in_valid = 4'b0100; clear_model();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_ch !== '0 || in_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_async got v=%b ch=%0d rdy=%b want 0 0 0", out_valid, out_ch, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = '0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || in_ready !== '0) begin
        n_fail++;
        $display("FAIL reset_idle got v=%b d=%h ch=%0d rdy=%b want 0 0 0 0", out_valid, out_data, out_ch, in_ready);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 4'b0100; set_data(2, 8'hA5); out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready got %b want 0100", in_ready);
    end
    @(posedge clk); #1;
    in_valid = '0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      n_fail++;
      $display("FAIL single_out got v=%b d=%h ch=%0d want 1 a5 2", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N_CH; i++) set_data(i, DATA_W'(8'h10 + i));
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_ch !== CH_W'(k % N_CH) || out_data !== DATA_W'(8'h10 + (k % N_CH))) begin
        n_fail++;
        $display("FAIL rr_seq[%0d] got v=%b ch=%0d d=%h want 1 %0d %h", k, out_valid, out_ch, out_data,
                 k % N_CH, 8'h10 + (k % N_CH));
      end
    end
    @(posedge clk); #1;
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 4'b0010; set_data(1, 8'h3C); out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 4'b1001; set_data(0, 8'hC0); set_data(3, 8'hC3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== '0 || out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got rdy=%b v=%b d=%h ch=%0d want 0000 1 3c 1", k, in_ready, out_valid, out_data, out_ch);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL bp_release_ready got %b want 1000", in_ready);
    end
    @(posedge clk); #1;
    in_valid = '0;
    @(negedge clk);
    n_checks++;
    if (out_ch !== 2'd3 || out_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL bp_release_out got ch=%0d d=%h want 3 c3", out_ch, out_data);
    end
  endtask

  task automatic test_skip_wrap();
    do_reset();
    in_valid = 4'b0100; set_data(2, 8'h22); out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 4'b0010; set_data(1, 8'h11);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL wrap_ready got %b want 0010", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 4'b1111;
    @(negedge clk);
    n_checks++;
    if (out_ch !== 2'd1 || in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL wrap_ptr got ch=%0d rdy=%b want 1 0100", out_ch, in_ready);
    end
    @(posedge clk); #1;
    in_valid = '0;
  endtask

  task automatic test_random_traffic();
    logic [N_CH-1:0] acc;
    int wait_beats[N_CH];
    int max_wait;
    do_reset();
    max_wait = 0;
    for (int i = 0; i < N_CH; i++) wait_beats[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      for (int i = 0; i < N_CH; i++) begin
        if (acc[i]) wait_beats[i] = 0;
        else if (in_valid[i] && acc != '0) wait_beats[i]++;
        if (wait_beats[i] > max_wait) max_wait = wait_beats[i];
      end
      @(posedge clk); #1;
      for (int i = 0; i < N_CH; i++) begin
        if (!in_valid[i] || acc[i]) begin
          in_valid[i] = ($urandom_range(0, 3) != 0);
          set_data(i, DATA_W'($urandom));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (max_wait > N_CH - 1) begin
      n_fail++;
      $display("FAIL fairness got max wait %0d beats want <= %0d", max_wait, N_CH - 1);
    end
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain got v=%b pending=%0d want 0 0", out_valid, exp_q.size());
    end
  endtask

`ifdef RR_MUX_CNT_EN
  task automatic test_counter();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (beat_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL cnt_reset got %0d want 0", beat_cnt);
    end
    @(posedge clk); #1;
    in_valid = 4'b0001; set_data(0, 8'h77); out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 in_valid = '0;
    @(negedge clk);
    n_checks++;
    if (beat_cnt !== 16'd10) begin
      n_fail++;
      $display("FAIL cnt_ten got %0d want 10", beat_cnt);
    end
    @(posedge clk); #1;
    in_valid = 4'b0001; cnt_clr = 1'b1;
    @(posedge clk); #1;
    in_valid = '0; cnt_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (beat_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL cnt_clr_wins got %0d want 0", beat_cnt);
    end
    @(posedge clk); #1;
    in_valid = 4'b0001;
    repeat (65535) @(posedge clk);
    #1 in_valid = '0;
    @(negedge clk);
    n_checks++;
    if (beat_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL cnt_full got %h want ffff", beat_cnt);
    end
    @(posedge clk); #1;
    in_valid = 4'b0001;
    @(posedge clk); #1;
    in_valid = '0;
    @(negedge clk);
    n_checks++;
    if (beat_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL cnt_saturate got %h want ffff", beat_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_skip_wrap();
    test_random_traffic();
`ifdef RR_MUX_CNT_EN
    test_counter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel round-robin arbitrating multiplexer with valid/ready handshake on every input and on the output.
- Selects one requesting channel per accepted beat and registers its data and channel index into a single-entry output stage.
- Sits between several producer blocks and one shared consumer.
- Generalises the fixed 2:1 combinational mux to DATA_W bits × N_CH channels, with fair arbitration and backpressure.

Parameters:
- N_CH, 4, number of input channels; legal range 2..16.
- DATA_W, 8, data width per channel in bits; ≥1.
- CH_W, $clog2(N_CH), width of the channel index (derived localparam, not overridable).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N_CH  per-channel request; bit i belongs to channel i.
- in_data  input  N_CH*DATA_W  flattened channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  N_CH  per-channel accept; combinational.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  registered selected data.
- out_ch  output  CH_W  registered index of the channel that supplied out_data.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready=0 while rst is high.
- Output register states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- load_en = !out_valid || out_ready. The register accepts a new beat when it is empty or drains in the same cycle.
- Grant: first channel i with in_valid[i]=1, searched in order rr_ptr, rr_ptr+1, …, N_CH-1, 0, …, rr_ptr-1 (wraps modulo N_CH).
- in_ready[i] = load_en && (i == grant) && |in_valid. At most one in_ready bit is high per cycle.
- Transfer on channel i when in_valid[i] && in_ready[i]. On that edge:
  - out_data <= in_data[i]; out_ch <= i; out_valid <= 1.
  - rr_ptr <= (i+1) mod N_CH.
- Output drain: out_valid && out_ready with no input transfer in the same cycle -> out_valid <= 0. out_data and out_ch hold their values.
- Simultaneous drain and load: the new beat replaces the old one. out_valid stays 1, with no bubble.
- FULL && !out_ready: in_ready=0 on every channel; out_data and out_ch are held stable; rr_ptr is held.
- No requests: rr_ptr is unchanged. The pointer advances only on an accepted beat, never while idle.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat per cycle while out_ready=1.
- Fairness: a continuously requesting channel is granted within N_CH accepted beats.
- Producer rules: a producer must hold in_valid and in_data stable until it sees in_ready. The grant may move to another channel while a channel waits. That is legal, because ready is never asserted without an accept.
- Reset mid-operation: any beat in the output register is discarded and the pointer returns to 0.

Optional Feature:
- Macro: RR_MUX_CNT_EN.
- Defined:
  - Adds output port beat_cnt (16 bits), which counts input handshakes.
  - Saturates at 16'hFFFF. Resets to 0.
  - Adds input cnt_clr (1 bit), a synchronous clear. When a clear and an increment occur in the same cycle, the clear wins (result 0).
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Decomposition:
- Shared package/header rr_mux_pkg holds:
  - RR_MUX_MAX_CH = 16.
  - Function ch_index_w(n), returning the clog2 value with a minimum of 1.
  - BEAT_CNT_W = 16.
- One natural sub-module: rr_arbiter. It takes in_valid, rr_ptr and an advance strobe, and owns the rotating priority search and the pointer register. It outputs grant index and any_valid.
- The top level keeps the handshake, the data mux and the output register.

Test Plan:
- Reset/idle: assert rst mid-stream with out_valid=1 -> out_valid=0, out_ch=0, in_ready=0 immediately (asynchronously). After release, with no in_valid, all outputs stay 0.
- Single channel: N_CH=4, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_ch=2.
- Round-robin: in_valid=4'b1111 held, data ch i = 8'h10+i, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
- Backpressure: output FULL with ch1=8'h3C, out_ready=0 for 5 cycles, in_valid=4'b1001 -> in_ready=0 throughout; out_data=3C and out_ch=1 stable. On out_ready=1, ch3 is granted (pointer=2, so ch3 comes before ch0).
- Skip/wrap: rr_ptr=3, in_valid=4'b0010 -> ch1 granted; rr_ptr becomes 2.
- RR_MUX_CNT_EN: 10 accepted beats -> beat_cnt=10. cnt_clr pulsed together with a beat -> beat_cnt=0. Force 0xFFFF plus one more beat -> stays 0xFFFF.
